// File: rtl/word_tokenizer.sv
// Character-to-token lexer: splits a separator-delimited ASCII stream into
// BEGIN / END / OTHER tokens carrying word length and a running token count.
module word_tokenizer #(
  parameter int unsigned LEN_W = 8,
  parameter logic [7:0]  SEP   = 8'h20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       in_i,
  input  logic             in_valid_i,
  input  logic             flush_i,
  output logic             tok_valid_o,
  output logic [1:0]       tok_kind_o,
  output logic [LEN_W-1:0] tok_len_o,
  output logic [31:0]      word_cnt_o,
  output logic [3:0]       st_o
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_B     = 4'd1,
    S_BE    = 4'd2,
    S_BEG   = 4'd3,
    S_BEGI  = 4'd4,
    S_BEGIN = 4'd5,
    S_E     = 4'd6,
    S_EN    = 4'd7,
    S_END   = 4'd8,
    S_OTH   = 4'd9
  } state_e;

  localparam logic [1:0]       KIND_BEGIN = 2'd1;
  localparam logic [1:0]       KIND_END   = 2'd2;
  localparam logic [1:0]       KIND_OTHER = 2'd3;
  localparam logic [LEN_W-1:0] LEN_MAX    = {LEN_W{1'b1}};

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic             tok_valid_q;
  logic [1:0]       tok_kind_q;
  logic [LEN_W-1:0] tok_len_q;
  logic [31:0]      word_cnt_q;

  logic [7:0]       c_lc;
  logic             is_chr;
  logic             is_sep;
  state_e           adv_state;
  logic [LEN_W-1:0] len_inc;
  state_e           word_state;
  logic [LEN_W-1:0] word_len;
  logic             term;

  always_comb begin
    c_lc = in_i;
    if (in_i >= 8'h41 && in_i <= 8'h5A) c_lc = in_i | 8'h20;
    is_chr = in_valid_i && (in_i != SEP);
    is_sep = in_valid_i && (in_i == SEP);

    adv_state = S_OTH;
    case (state_q)
      S_IDLE: begin
        if (c_lc == "b")      adv_state = S_B;
        else if (c_lc == "e") adv_state = S_E;
      end
      S_B:    if (c_lc == "e") adv_state = S_BE;
      S_BE:   if (c_lc == "g") adv_state = S_BEG;
      S_BEG:  if (c_lc == "i") adv_state = S_BEGI;
      S_BEGI: if (c_lc == "n") adv_state = S_BEGIN;
      S_E:    if (c_lc == "n") adv_state = S_EN;
      S_EN:   if (c_lc == "d") adv_state = S_END;
      default: adv_state = S_OTH;
    endcase

    len_inc = (len_q == LEN_MAX) ? len_q : len_q + 1'b1;

    // A character arriving with flush is appended before the word closes.
    word_state = is_chr ? adv_state : state_q;
    word_len   = is_chr ? len_inc : len_q;
    term       = (is_sep || flush_i) && (word_state != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      tok_valid_q <= 1'b0;
      tok_kind_q  <= 2'd0;
      tok_len_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      tok_valid_q <= 1'b0;
      if (term) begin
        tok_valid_q <= 1'b1;
        case (word_state)
          S_BEGIN: tok_kind_q <= KIND_BEGIN;
          S_END:   tok_kind_q <= KIND_END;
          default: tok_kind_q <= KIND_OTHER;
        endcase
        tok_len_q  <= word_len;
        word_cnt_q <= word_cnt_q + 32'd1;
        state_q    <= S_IDLE;
        len_q      <= '0;
      end else if (is_chr) begin
        state_q <= adv_state;
        len_q   <= len_inc;
      end
    end
  end

  assign tok_valid_o = tok_valid_q;
  assign tok_kind_o  = tok_kind_q;
  assign tok_len_o   = tok_len_q;
  assign word_cnt_o  = word_cnt_q;
  assign st_o        = state_q;

endmodule

// File: doc/word_tokenizer.md
Name: word_tokenizer

Overview:
- Upstream lexer for the block-balance checker: consumes one ASCII character per cycle and emits one token per space-delimited word.
- Token kinds are BEGIN, END or OTHER, with the word length and a running word count.
- Keywords are matched case-insensitively.
- The downstream checker consumes tokens instead of raw characters.

Parameters:
- LEN_W, 8: width of the token length field. Length saturates at 2^LEN_W-1.
- SEP, 8'h20: separator character.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in  input  8  ASCII character
- in_valid  input  1  the value on `in` is consumed this cycle
- flush  input  1  end-of-stream; terminates any open word
- tok_valid  output  1  one-cycle pulse; token fields are valid
- tok_kind  output  2  0 = none, 1 = BEGIN, 2 = END, 3 = OTHER
- tok_len  output  LEN_W  character count of the word, saturating
- word_cnt  output  32  total tokens emitted since reset, wraps at 2^32
- st  output  4  current FSM state, for debug

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - tok_valid=0, tok_kind=0, tok_len=0, word_cnt=0.
  - The length accumulator is cleared.
  - Reset asserted mid-word discards the partial word; no token is emitted.
- FSM states:
  - IDLE: between words.
  - B, BE, BEG, BEGI, BEGIN.
  - E, EN, END.
  - OTH: word already disqualified from being a keyword.
- Transitions on in_valid with a non-separator character c (fold c to lowercase only if it is in A–Z):
  - IDLE: 'b' goes to B, 'e' goes to E, anything else goes to OTH.
  - Each prefix state advances on the next matching letter, otherwise goes to OTH.
  - From BEGIN or END, any further character goes to OTH.
  - OTH stays in OTH.
  - The length accumulator increments, saturating at 2^LEN_W-1.
- Word termination (in_valid with in==SEP, or flush) while state != IDLE:
  - At the next rising edge: tok_valid=1; tok_kind is BEGIN if the state was BEGIN, END if it was END, otherwise OTHER.
  - tok_len = accumulated length; word_cnt increments.
  - State returns to IDLE and the accumulator clears.
- Latency: a token appears exactly one cycle after the terminating input is sampled.
- tok_valid is high for a single cycle.
- tok_kind and tok_len hold their last values when tok_valid=0.
- Separator or flush in IDLE:
  - No token is emitted.
  - Repeated separators never create empty tokens.
- in_valid=0 and flush=0: state, accumulator and outputs hold; tok_valid drops to 0.
- Simultaneous in_valid (non-separator) and flush:
  - The character is appended first, then the word terminates in the same edge.
  - The token includes that character.
  - Example: state BEGI, in='n', flush=1 gives a BEGIN token with len 5.
- Simultaneous in_valid (separator) and flush: a single token is emitted.
- NUL (8'h00) with in_valid=1 is treated as an ordinary non-separator character (goes to OTH).
- word_cnt wraps from 32'hFFFFFFFF to 0.
- Back-to-back operation is allowed:
  - A new word character may arrive in the cycle immediately after a separator.
  - A token may be emitted on the same edge the next word's first character is accepted.

Test Plan:
1. Reset, then feed "end begin endd word" plus flush, one char per cycle.
   - Tokens END/3, BEGIN/5, OTHER/4, OTHER/4.
   - Final word_cnt=4.
   - Each tok_valid occurs one cycle after the space (or after flush).
2. Feed "  BeGiN   eNd " with leading, repeated and trailing spaces.
   - Exactly two tokens: BEGIN/5 and END/3.
   - No empty tokens; word_cnt=2.
3. Feed "begi" then in='n' together with flush=1.
   - Single BEGIN/5 token the next cycle.
   - Then feed "x" with flush: OTHER/1.
4. Feed "beginx " and "en ".
   - OTHER/6, then OTHER/2.
   - Verifies overrun and prefix-only words are not keywords.
5. With LEN_W=3, feed a 10-letter word plus space.
   - OTHER with tok_len=7 (saturated).
6. Feed "begi", assert reset low for 1 cycle mid-word, then feed "end ".
   - Outputs go to 0 immediately (asynchronously).
   - No token for the discarded "begi".
   - Next token is END/3 with word_cnt=1.
